// File: rtl/moore_seq_pkg.sv
// rtl/moore_seq_pkg.sv - shared state encoding and default width for moore_seq_tx
package moore_seq_pkg;

  localparam int WIDTH_DEFAULT = 16;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] SEND_ENC = 2'd1;
  localparam logic [1:0] GAP_ENC  = 2'd2;
  localparam logic [1:0] DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    SEND = SEND_ENC,
    GAP  = GAP_ENC,
    DONE = DONE_ENC
  } state_t;

endpackage

// File: rtl/moore_seq_shifter.sv
// rtl/moore_seq_shifter.sv - pattern load/shift register with selectable output bit
module moore_seq_shifter #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  input  logic [CW-1:0]    sel,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (load)
      q <= data;
    else if (shift)
      q <= {q[WIDTH-2:0], 1'b0};
  end

  assign msb = q[sel];

endmodule

// File: rtl/moore_seq_tx.sv
// rtl/moore_seq_tx.sv - serial pattern transmitter with repetitions and inter-repetition gaps
module moore_seq_tx
  import moore_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CW-1:0]    len,
  input  logic [3:0]       reps,
  input  logic [2:0]       gap,
  output logic             d,
  output logic             d_valid,
  output logic             ready,
  output logic             done
);

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_pattern;
  logic [CW-1:0]    sh_len;
  logic [2:0]       sh_gap;
  logic [CW-1:0]    bit_cnt, bit_n;
  logic [3:0]       rep_cnt, rep_n;
  logic [2:0]       gap_cnt, gap_n;
  logic             d_n, d_valid_n, ready_n, done_n;
  logic             capture, load, shift, next_bit;
  logic [WIDTH-1:0] load_data;

  // The shifter holds the bits still to come, so its selected bit is always the next one to send.
  moore_seq_shifter #(.WIDTH(WIDTH), .CW(CW)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (load_data),
    .sel   (sh_len),
    .msb   (next_bit)
  );

  always_comb begin
    state_n   = state;
    d_n       = 1'b0;
    d_valid_n = 1'b0;
    ready_n   = 1'b0;
    done_n    = 1'b0;
    bit_n     = bit_cnt;
    rep_n     = rep_cnt;
    gap_n     = gap_cnt;
    capture   = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    load_data = sh_pattern << 1;
    case (state)
      IDLE: begin
        ready_n = 1'b1;
        if (start) begin
          capture   = 1'b1;
          load      = 1'b1;
          load_data = pattern << 1;
          state_n   = SEND;
          d_n       = pattern[len];
          d_valid_n = 1'b1;
          ready_n   = 1'b0;
          bit_n     = len;
          rep_n     = reps;
        end
      end
      SEND: begin
        if (bit_cnt != '0) begin
          shift     = 1'b1;
          d_n       = next_bit;
          d_valid_n = 1'b1;
          bit_n     = bit_cnt - CW'(1);
        end else if (rep_cnt != 4'd0) begin
          rep_n = rep_cnt - 4'd1;
          bit_n = sh_len;
          if (sh_gap != 3'd0) begin
            state_n = GAP;
            gap_n   = sh_gap - 3'd1;
          end else begin
            load      = 1'b1;
            d_n       = sh_pattern[sh_len];
            d_valid_n = 1'b1;
          end
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == 3'd0) begin
          state_n   = SEND;
          load      = 1'b1;
          d_n       = sh_pattern[sh_len];
          d_valid_n = 1'b1;
        end else begin
          gap_n = gap_cnt - 3'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      d          <= 1'b0;
      d_valid    <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      bit_cnt    <= '0;
      rep_cnt    <= 4'd0;
      gap_cnt    <= 3'd0;
      sh_pattern <= '0;
      sh_len     <= '0;
      sh_gap     <= 3'd0;
    end else begin
      state   <= state_n;
      d       <= d_n;
      d_valid <= d_valid_n;
      ready   <= ready_n;
      done    <= done_n;
      bit_cnt <= bit_n;
      rep_cnt <= rep_n;
      gap_cnt <= gap_n;
      if (capture) begin
        sh_pattern <= pattern;
        sh_len     <= len;
        sh_gap     <= gap;
      end
    end
  end

endmodule

// File: tb/tb_moore_seq_tx.sv
// tb/tb_moore_seq_tx.sv - directed self-checking bench for moore_seq_tx
module tb_moore_seq_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [3:0]  len;
  logic [3:0]  reps;
  logic [2:0]  gap;
  logic        d, d_valid, ready, done;

  int errors   = 0;
  int checks   = 0;
  int dv_count = 0;
  int done_cnt = 0;

  // Reference 1011 Moore detector fed by the serial line
  logic [3:0] hist;
  logic       y;

  always #5 clk = ~clk;

  moore_seq_tx dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .gap     (gap),
    .d       (d),
    .d_valid (d_valid),
    .ready   (ready),
    .done    (done)
  );

  always @(posedge clk) begin
    if (reset) hist <= 4'd0;
    else       hist <= {hist[2:0], d};
  end
  assign y = (hist == 4'b1011);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {d_valid, d, done, ready} in the current cycle, then advances one cycle.
  task automatic expect_cyc(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, d_valid, d, done, ready}, {28'd0, exp});
    if (d_valid) dv_count++;
    step();
  endtask

  task automatic run_vec(input string name, input logic [47:0] codes, input int n);
    for (int i = 0; i < n; i++)
      expect_cyc($sformatf("%s_c%0d", name, i + 1), codes[4*(n-1-i) +: 4]);
  endtask

  task automatic kick(input logic [15:0] p, input logic [3:0] l,
                      input logic [3:0] r, input logic [2:0] g);
    pattern = p;
    len     = l;
    reps    = r;
    gap     = g;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; len = '0; reps = '0; gap = '0;
    step();
    step();
    check("reset_state", {28'd0, d_valid, d, done, ready}, 32'h1);
    reset = 1'b0;
    step();

    // Single 4-bit pattern 1011
    dv_count = 0;
    kick(16'h000B, 4'd3, 4'd0, 3'd0);
    run_vec("single", 48'hC8CC21, 6);
    check("single_dv", dv_count, 4);

    // Two repetitions of 101 separated by two idle cycles
    dv_count = 0;
    kick(16'h0005, 4'd2, 4'd1, 3'd2);
    run_vec("gap", 48'hC8C00C8C21, 10);
    check("gap_dv", dv_count, 6);

    // Single-bit pattern, four back-to-back repetitions
    dv_count = 0;
    kick(16'h0001, 4'd0, 4'd3, 3'd0);
    run_vec("b2b", 48'hCCCC21, 6);
    check("b2b_dv", dv_count, 4);

    // Busy start and input changes during SEND are ignored
    kick(16'h000B, 4'd3, 4'd0, 3'd0);
    expect_cyc("busy_c1", 4'hC);
    start = 1'b1; pattern = 16'h0000; len = 4'd0; reps = 4'd5; gap = 3'd7;
    expect_cyc("busy_c2", 4'h8);
    expect_cyc("busy_c3", 4'hC);
    start = 1'b0;
    expect_cyc("busy_c4", 4'hC);
    expect_cyc("busy_c5", 4'h2);
    run_vec("busy_idle", 48'h111, 3);

    // Reset during the third bit of a 16-bit transfer aborts it
    kick(16'hFFFF, 4'd15, 4'd0, 3'd0);
    expect_cyc("abort_c1", 4'hC);
    expect_cyc("abort_c2", 4'hC);
    check("abort_c3", {28'd0, d_valid, d, done, ready}, 32'hC);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_after", {28'd0, d_valid, d, done, ready}, 32'h1);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      step();
    end
    check("abort_nodone", done_cnt, 0);

    // Reset wins over a start sampled on the same edge
    reset = 1'b1; start = 1'b1; pattern = 16'h000F; len = 4'd3;
    step();
    reset = 1'b0; start = 1'b0;
    run_vec("rst_prio", 48'h111, 3);

    // Loopback into the 1011 detector
    kick(16'h000B, 4'd3, 4'd0, 3'd0);
    expect_cyc("loop_c1", 4'hC);
    expect_cyc("loop_c2", 4'h8);
    expect_cyc("loop_c3", 4'hC);
    check("loop_y_c4", {31'd0, y}, 32'd0);
    expect_cyc("loop_c4", 4'hC);
    check("loop_y_c5", {31'd0, y}, 32'd1);
    expect_cyc("loop_c5", 4'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore_seq_tx.md
MOORE_SEQ_TX -- requirements
Module: moore_seq_tx

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the maximum pattern length in bits.
REQ-002 Parameter CW, default 4, SHALL be $clog2(WIDTH) and size the len port.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1: reset, synchronous, active-high.
REQ-005 Port start, input, 1: transmit request, accepted only on an edge where ready=1.
REQ-006 Port pattern, input, WIDTH: bits to send, MSB-first, starting at pattern[len].
REQ-007 Port len, input, CW: number of bits minus 1 (0 gives 1 bit, WIDTH-1 gives WIDTH bits).
REQ-008 Port reps, input, 4: number of pattern repetitions minus 1.
REQ-009 Port gap, input, 3: idle cycles inserted between repetitions.
REQ-010 Port d, output, 1: serial data bit, registered.
REQ-011 Port d_valid, output, 1: high when d carries a pattern bit, registered.
REQ-012 Port ready, output, 1: high when idle and able to accept start, registered.
REQ-013 Port done, output, 1: one-cycle pulse after the final bit of the final repetition, registered.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SEND, GAP and DONE.
REQ-015 IDLE SHALL drive ready=1, d=0, d_valid=0 and done=0.
REQ-016 IDLE with start=1 at edge N SHALL capture pattern, len, reps and gap into shadow registers and enter SEND.
REQ-017 The first bit pattern[len] SHALL appear on d with d_valid=1 in the cycle after edge N, which is a latency of 1.
REQ-018 SEND SHALL present one bit per cycle, descending from bit len to bit 0.
REQ-019 SEND SHALL hold d_valid=1 and ready=0 throughout.
REQ-020 Pattern bits above len SHALL be ignored.
REQ-021 After bit 0, if repetitions remain and gap>0, the FSM SHALL enter GAP for exactly gap cycles with d=0 and d_valid=0, then return to SEND reloaded from the shadow pattern.
REQ-022 After bit 0, if repetitions remain and gap=0, the next repetition's first bit SHALL follow in the very next cycle with no bubble.
REQ-023 After bit 0 of the final repetition, the FSM SHALL enter DONE for one cycle with done=1, d=0, d_valid=0 and ready=0, then enter IDLE.
REQ-024 start while ready=0 SHALL be ignored, with no queuing.
REQ-025 Changes on pattern, len, reps or gap after capture SHALL NOT affect the transfer in progress.
REQ-026 A bit counter SHALL wrap from 0 to the shadow len when a repetition ends.
REQ-027 A repetition counter SHALL decrement once per completed repetition and never underflow.
REQ-028 Total d_valid cycles per transfer SHALL equal (len+1)*(reps+1).

Reset
REQ-029 reset=1 at any edge SHALL force IDLE and set d=0, d_valid=0, done=0, ready=1, and clear all counters and shadow registers.
REQ-030 Reset SHALL take priority over start sampled at the same edge; that start SHALL be dropped.
REQ-031 Reset asserted mid-SEND or mid-GAP SHALL abort the transfer with no done pulse.

Structure
REQ-032 Package moore_seq_pkg SHALL hold the state encoding localparams (IDLE=0, SEND=1, GAP=2, DONE=3) and the WIDTH default.
REQ-033 The pattern load/shift register SHALL be sub-module moore_seq_shifter, with load, shift and an MSB-select input.
REQ-034 The FSM, the bit counter, the repetition counter and the gap counter SHALL reside in moore_seq_tx.

Verification
REQ-035 Single 4-bit pattern: pattern=16'h000B, len=3, reps=0, gap=0, start pulse -> d=1,0,1,1 with d_valid on 4 consecutive cycles, done at cycle 5, ready=1 at cycle 6.
REQ-036 Repetition with gap: pattern=16'h0005, len=2, reps=1, gap=2 -> d=1,0,1, then 2 idle cycles, then 1,0,1, then one done pulse; 6 d_valid cycles total.
REQ-037 Back-to-back: len=0, pattern=1, reps=3, gap=0 -> 4 contiguous d_valid cycles with d=1 and no bubble.
REQ-038 Busy start and input change: start pulsed and pattern changed during SEND -> output stream unchanged, no second transfer.
REQ-039 Mid-transfer reset: reset=1 during bit 2 of a 16-bit transfer -> next cycle d_valid=0, ready=1, done never pulses.
REQ-040 Loopback: d drives top_moore_fsm (reset inverted) with pattern 1011 -> detector y=1 in the cycle after the last bit.
